// File: rtl/obf_key_cell_bank_if.sv
// obf_key_cell_bank_if: net bus and serial key-load handshake for obf_key_cell_bank
interface obf_key_cell_bank_if #(parameter int CHANNELS = 5);
    logic [CHANNELS-1:0] din;
    logic [CHANNELS-1:0] dout;
    logic load_start;
    logic key_valid;
    logic key_bit;
    logic key_ready;
    logic key_done;
    logic key_err;
    logic loading;
    modport master (
        output din, load_start, key_valid, key_bit,
        input dout, key_ready, key_done, key_err, loading
    );
    modport slave (
        input din, load_start, key_valid, key_bit,
        output dout, key_ready, key_done, key_err, loading
    );
endinterface

// File: rtl/obf_key_cell_bank.sv
// obf_key_cell_bank: serially keyed bank of pass/invert/const camouflage cells; OBF_KEY_PARITY_EN adds an even-parity key bit and a CHECK state
module obf_key_cell_bank #(
    parameter int CHANNELS = 5,
    parameter bit OUT_REG = 1'b0
) (
    input logic clk,
    input logic rst,
    obf_key_cell_bank_if.slave bus
);
    localparam int KW = 2 * CHANNELS;
`ifdef OBF_KEY_PARITY_EN
    localparam int NB = KW + 1;
`else
    localparam int NB = KW;
`endif
    localparam bit PAR = NB != KW;
    localparam int CW = $clog2(NB + 1);
    localparam logic [CW-1:0] LAST = CW'(NB - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK, COMMIT} state_t;

    state_t state, nxt;
    logic [CW-1:0] cnt;
    logic [KW-1:0] shadow;
    logic [KW-1:0] active;
    logic [CHANNELS-1:0] y;
    logic accept;
    logic last;
    logic par_ok;

    // a bit offered together with load_start is discarded by the restart
    assign accept = state == SHIFT && bus.key_valid && !bus.load_start;
    assign last = cnt == LAST;

`ifdef OBF_KEY_PARITY_EN
    logic par_bit;
    logic err;
    assign par_ok = ~^{shadow, par_bit};
    assign bus.key_err = err;
    // capture the trailing parity bit; error is sticky until the next load
    always_ff @(posedge clk) begin
        if (rst) begin
            par_bit <= 1'b0;
            err <= 1'b0;
        end else begin
            if (accept && last) par_bit <= bus.key_bit;
            err <= bus.load_start ? 1'b0 : (state == CHECK && !par_ok) ? 1'b1 : err;
        end
    end
`else
    assign par_ok = 1'b1;
    assign bus.key_err = 1'b0;
`endif

    // state register, bit counter, shadow shifter and atomic commit into the active key
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            shadow <= '0;
            active <= '0;
        end else begin
            state <= nxt;
            if (state == COMMIT) active <= shadow;
            if (bus.load_start) begin
                cnt <= '0;
                shadow <= '0;
            end else if (accept) begin
                cnt <= cnt + 1'b1;
                if (!(PAR && last)) shadow <= {shadow[KW-2:0], bus.key_bit};
            end
        end
    end

    // next state and handshake outputs; load_start restarts from any state
    always_comb begin
        nxt = bus.load_start ? SHIFT
            : state == SHIFT ? ((accept && last) ? (PAR ? CHECK : COMMIT) : SHIFT)
            : (state == CHECK && par_ok) ? COMMIT
            : IDLE;
        bus.key_ready = state == SHIFT;
        bus.key_done = state == COMMIT;
        bus.loading = state != IDLE;
    end

    // per-channel cell: {sel_const, sel_alt} picks pass, invert, const-1 or const-0
    always_comb begin
        y = '0;
        for (int i = 0; i < CHANNELS; i++)
            y[i] = active[2*i+1] ? ~active[2*i] : bus.din[i] ^ active[2*i];
    end

    if (OUT_REG) begin : g_reg
        // registered outputs add one cycle of latency
        always_ff @(posedge clk) bus.dout <= rst ? '0 : y;
    end else begin : g_comb
        assign bus.dout = y;
    end
endmodule

// File: tb/tb_obf_key_cell_bank.sv
// tb_obf_key_cell_bank: scoreboard bench driving a combinational and a registered bank from one stimulus stream
module tb_obf_key_cell_bank;
  localparam int CH = 5;
  localparam int KW = 10;
`ifdef OBF_KEY_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  obf_key_cell_bank_if #(.CHANNELS(CH)) b0 ();
  obf_key_cell_bank_if #(.CHANNELS(CH)) b1 ();
  obf_key_cell_bank #(.CHANNELS(CH), .OUT_REG(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  obf_key_cell_bank #(.CHANNELS(CH), .OUT_REG(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  typedef struct {
    logic [4:0] d0;
    logic [4:0] d1;
    logic [4:0] l0;
    logic [4:0] l1;
    bit h0;
    bit h1;
    logic rdy;
    logic done;
    logic ld;
    logic err;
    string tag;
  } exp_t;
  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;
  bit m_shift, m_check, m_commit, m_err;
  int m_cnt, m_sh, m_pb;
  logic [9:0] m_act;
  logic [4:0] m_prev;
  function automatic logic [4:0] cells(input logic [9:0] k, input logic [4:0] d);
    logic [4:0] r;
    int m;
    for (int i = 0; i < CH; i++) begin
      m = int'(k >> (2 * i)) & 3;
      case (m)
        0: r[i] = d[i];
        1: r[i] = ~d[i];
        2: r[i] = 1'b1;
        default: r[i] = 1'b0;
      endcase
    end
    return r;
  endfunction
  task automatic cyc(input logic r, input logic l, input logic v, input logic bb, input logic [4:0] d,
                     input logic [4:0] l0, input bit h0, input logic [4:0] l1, input bit h1,
                     input string tag, input bit chk);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    b0.load_start = l; b1.load_start = l;
    b0.key_valid = v;  b1.key_valid = v;
    b0.key_bit = bb;   b1.key_bit = bb;
    b0.din = d;        b1.din = d;
    if (chk) begin
      e.d0 = cells(m_act, d);
      e.d1 = m_prev;
      e.l0 = l0; e.h0 = h0;
      e.l1 = l1; e.h1 = h1;
      e.rdy = m_shift;
      e.done = m_commit;
      e.ld = m_shift | m_check | m_commit;
      e.err = m_err;
      e.tag = tag;
      q.push_back(e);
    end
    if (r) begin
      m_shift = 0; m_check = 0; m_commit = 0; m_err = 0;
      m_cnt = 0; m_sh = 0; m_act = '0; m_prev = '0;
    end else begin
      m_prev = cells(m_act, d);
      if (m_commit) m_act = 10'(m_sh);
      if (l) begin
        m_err = 0; m_shift = 1; m_check = 0; m_commit = 0; m_cnt = 0; m_sh = 0;
      end else if (m_commit) begin
        m_commit = 0;
      end else if (m_check) begin
        m_check = 0;
        if ((($countones(m_sh) + m_pb) % 2) == 0) m_commit = 1;
        else m_err = 1;
      end else if (m_shift && v) begin
        if (m_cnt < KW) m_sh = ((m_sh << 1) | int'(bb)) & ((1 << KW) - 1);
        else m_pb = int'(bb);
        m_cnt++;
        if (m_cnt == KW + int'(PAR)) begin
          m_shift = 0;
          if (PAR) m_check = 1;
          else m_commit = 1;
        end
      end
    end
  endtask
  task automatic step(input logic l, input logic v, input logic bb, input logic [4:0] d);
    cyc(1'b0, l, v, bb, d, 5'd0, 1'b0, 5'd0, 1'b0, "seq", 1'b1);
  endtask
  task automatic lit(input logic [4:0] d, input logic [4:0] l0, input logic [4:0] l1, input bit h1, input string tag);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, d, l0, 1'b1, l1, h1, tag, 1'b1);
  endtask
  task automatic load_key(input logic [9:0] k, input bit pflip, input logic vs);
    step(1'b1, vs, 1'b1, 5'($urandom));
    for (int i = KW - 1; i >= 0; i--) step(1'b0, 1'b1, k[i], 5'($urandom));
    if (PAR) begin
      step(1'b0, 1'b1, (^k) ^ pflip, 5'($urandom));
      step(1'b0, 1'b0, 1'b0, 5'($urandom));
    end
    step(1'b0, 1'b0, 1'b0, 5'($urandom));
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      if (b0.dout !== e.d0 || b1.dout !== e.d1 || (e.h0 && b0.dout !== e.l0) || (e.h1 && b1.dout !== e.l1)
          || b0.key_ready !== e.rdy || b1.key_ready !== e.rdy || b0.key_done !== e.done || b1.key_done !== e.done
          || b0.loading !== e.ld || b1.loading !== e.ld || b0.key_err !== e.err || b1.key_err !== e.err) begin
        miscompares++;
        $display("FAIL %s: got dout0=%b dout1=%b rdy=%b/%b done=%b/%b loading=%b/%b err=%b/%b; want dout0=%b(lit %b:%b) dout1=%b(lit %b:%b) rdy=%b done=%b loading=%b err=%b",
                 e.tag, b0.dout, b1.dout, b0.key_ready, b1.key_ready, b0.key_done, b1.key_done,
                 b0.loading, b1.loading, b0.key_err, b1.key_err,
                 e.d0, e.h0, e.l0, e.d1, e.h1, e.l1, e.rdy, e.done, e.ld, e.err);
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    b0.din = '0; b1.din = '0;
    b0.load_start = 0; b1.load_start = 0;
    b0.key_valid = 0; b1.key_valid = 0;
    b0.key_bit = 0; b1.key_bit = 0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, "reset", 1'b0);
    lit(5'b10110, 5'b10110, 5'b00000, 1'b1, "reset_pass");
    @(negedge clk);
    if (b0.dout !== 5'b10110) begin
      miscompares++;
      $display("FAIL direct_reset: dout0=%b want 10110", b0.dout);
    end
    if (b1.dout !== 5'b00000) begin
      miscompares++;
      $display("FAIL direct_reset: dout1=%b want 00000", b1.dout);
    end
    if (b0.key_ready !== 1'b0 || b1.key_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL direct_reset: key_ready=%b/%b want 0", b0.key_ready, b1.key_ready);
    end
    if (b0.loading !== 1'b0 || b1.loading !== 1'b0) begin
      miscompares++;
      $display("FAIL direct_reset: loading=%b/%b want 0", b0.loading, b1.loading);
    end
    load_key(10'b11_10_01_00_00, 1'b0, 1'b0);
    lit(5'b11111, 5'b01011, 5'd0, 1'b0, "key1_ones");
    lit(5'b00000, 5'b01100, 5'd0, 1'b0, "key1_zeros");
    step(1'b1, 1'b0, 1'b0, 5'd0);
    for (int i = 9; i >= 5; i--) step(1'b0, 1'b1, i[0], 5'($urandom));
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'($urandom), 5'b11111, 5'b01011, 1'b1, 5'd0, 1'b0, "stall_old_key", 1'b1);
    begin
      logic [9:0] k2;
      k2 = 10'b00_11_01_10_00;
      step(1'b1, 1'b0, 1'b0, 5'd0);
      for (int i = KW - 1; i >= 5; i--) step(1'b0, 1'b1, k2[i], 5'($urandom));
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'($urandom), 5'b11111, 5'b01011, 1'b1, 5'd0, 1'b0, "stall_hold", 1'b1);
      for (int i = 4; i >= 0; i--) step(1'b0, 1'b1, k2[i], 5'($urandom));
      if (PAR) begin
        step(1'b0, 1'b1, ^k2, 5'($urandom));
        step(1'b0, 1'b0, 1'b0, 5'($urandom));
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'b11111, 5'b01011, 1'b1, 5'd0, 1'b0, "commit_cycle_old_key", 1'b1);
      lit(5'b10101, 5'b10011, 5'd0, 1'b0, "stall_key");
    end
    step(1'b1, 1'b0, 1'b0, 5'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 5'($urandom));
    load_key(10'b01_01_01_01_01, 1'b0, 1'b1);
    lit(5'b00110, 5'b11001, 5'd0, 1'b0, "restart_key");
    step(1'b0, 1'b0, 1'b0, 5'b00000);
    lit(5'b11111, 5'b00000, 5'd0, 1'b0, "oreg_t");
    lit(5'b11111, 5'b00000, 5'b00000, 1'b1, "oreg_t1");
    step(1'b1, 1'b0, 1'b0, 5'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'($urandom), 5'($urandom));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'b10101, 5'd0, 1'b0, 5'd0, 1'b0, "rst_mid", 1'b1);
    lit(5'b10101, 5'b10101, 5'b00000, 1'b1, "rst_dout_zero");
    lit(5'b10101, 5'b10101, 5'b10101, 1'b1, "rst_pass");
    if (PAR) begin
      load_key(10'b00_00_00_00_11, 1'b1, 1'b0);
      lit(5'b11111, 5'b11111, 5'd0, 1'b0, "parity_bad");
      load_key(10'b00_00_00_00_11, 1'b0, 1'b0);
      lit(5'b11111, 5'b11110, 5'd0, 1'b0, "parity_good");
    end
    for (int i = 0; i < 600; i++)
      cyc(1'($urandom_range(149) == 0), 1'($urandom_range(29) == 0), 1'($urandom_range(9) < 7),
          1'($urandom), 5'($urandom), 5'd0, 1'b0, 5'd0, 1'b0, "random", 1'b1);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    if (vectors < 600) $display("FAIL too few vectors: %0d", vectors);
    if (miscompares != 0) $display("FAIL %0d miscompares", miscompares);
    else $display("PASS");
    $finish;
  end
endmodule
